// File: rtl/sram_port_master.sv
// sram_port_master
// Host-side initiator for one OpenRAM single-port RW macro port. Requests arrive on a
// valid/ready stream and are turned into registered csb0/web0/addr0/din0 activity.
// Read data comes back two cycles after acceptance. It is captured into a small
// first-word fall-through FIFO so the host may stall responses without losing data.
// Credits are counted across the FIFO and the two-stage read pipeline, which means
// a returning read always has a FIFO slot waiting for it.

module sram_port_master #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  clk0,
   input  logic                  rst0,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   // Pointer, occupancy and credit-sum widths. The credit sum can reach
   // RSP_DEPTH + 2 transiently in the arithmetic, so it gets one bit more than the count.
   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = PTR_W + 2;

   // SRAM pin registers
   logic                  csb_q, csb_d;
   logic                  web_q, web_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;

   // Read tag pipeline: one bit per cycle of SRAM latency
   logic                  rd_s1_q, rd_s1_d;
   logic                  rd_s2_q, rd_s2_d;

   // Response FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_mem_d [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   // Handshake events for the current cycle
   logic [SUM_W-1:0]      credits_used;
   logic                  accept;
   logic                  push;
   logic                  pop;

   // Handshakes. A slot is spoken for as soon as a read is accepted, so reads still
   // in the SRAM pipeline count against the FIFO depth alongside the stored entries.
   // Writes consume the same credit check so req_ready never depends on req_we.
   // The FIFO is first-word fall-through: the head entry is always on rsp_rdata.
   always_comb begin
      credits_used = SUM_W'(count_q) + SUM_W'(rd_s1_q) + SUM_W'(rd_s2_q);
      req_ready    = !rst0 && (credits_used < SUM_W'(RSP_DEPTH));
      accept       = req_valid && req_ready;
      push         = rd_s2_q;
      rsp_valid    = (count_q != '0);
      pop          = rsp_valid && rsp_ready;
      rsp_rdata    = fifo_mem_q[rd_ptr_q];
   end

   // SRAM pin next-state. An accepted request drives the macro for exactly one cycle.
   // Otherwise the chip is deselected. Address and write data hold their last values,
   // which keeps the pins quiet, and din0 only changes on a write.
   always_comb begin
      csb_d  = !accept;
      web_d  = !(accept && req_we);
      addr_d = accept ? req_addr : addr_q;
      din_d  = (accept && req_we) ? req_wdata : din_q;
   end

   // Read tag pipeline. The macro captures the read one edge after acceptance and
   // drives dout0 during that cycle. The tag reaches rd_s2 just as dout0 is valid,
   // so dout0 is sampled at the edge two cycles after acceptance.
   always_comb begin
      rd_s1_d = accept && !req_we;
      rd_s2_d = rd_s1_q;
   end

   // Response FIFO next-state. Pointers wrap naturally because the depth is a power
   // of two. A simultaneous push and pop leaves the count alone, even when full.
   always_comb begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
         fifo_mem_d[i] = fifo_mem_q[i];
      end
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_mem_d[wr_ptr_q] = dout0;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers. Reset deselects the SRAM and drops any reads still in flight
   // so they never reach the FIFO. It also empties the FIFO and clears its storage,
   // so the head word reads as zero.
   always_ff @(posedge clk0) begin
      if (rst0) begin
         csb_q    <= 1'b1;
         web_q    <= 1'b1;
         addr_q   <= '0;
         din_q    <= '0;
         rd_s1_q  <= 1'b0;
         rd_s2_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         csb_q    <= csb_d;
         web_q    <= web_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rd_s1_q  <= rd_s1_d;
         rd_s2_q  <= rd_s2_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_mem_q[i] <= fifo_mem_d[i];
         end
      end
   end

   assign csb0  = csb_q;
   assign web0  = web_q;
   assign addr0 = addr_q;
   assign din0  = din_q;

endmodule

// File: tb/tb_sram_port_master.sv
// tb_sram_port_master
// Drives sram_port_master against a behavioural OpenRAM-style macro. Outputs are
// compared with a directed vector table and with a transaction-level reference
// model. The model keeps an ideal memory, a queue of reads in flight with their
// due edge, and a queue of responses waiting for the host.

module tb_sram_port_master;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 4;

   logic          clk0 = 1'b0;
   logic          rst0;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          csb0;
   logic          web0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0;

   sram_port_master #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk0      (clk0),
      .rst0      (rst0),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .csb0      (csb0),
      .web0      (web0),
      .addr0     (addr0),
      .din0      (din0),
      .dout0     (dout0)
   );

   // 10-unit clock period. The SRAM model below uses a 3-unit read delay, which is
   // shorter than the half period.
   always #5 clk0 = ~clk0;

   // Behavioural single-port macro. Pins are captured at the rising edge. A read
   // makes dout0 go unknown shortly after the edge and settle after the access delay.
   // A write commits at the following falling edge.
   logic [DW-1:0] sram_mem [256];

   always @(posedge clk0) begin : sram_model
      logic          s_csb;
      logic          s_web;
      logic [AW-1:0] s_addr;
      logic [DW-1:0] s_din;
      s_csb  = csb0;
      s_web  = web0;
      s_addr = addr0;
      s_din  = din0;
      if (!s_csb && s_web) begin
         #1;
         dout0 = 'x;
         #2;
         dout0 = sram_mem[s_addr];
      end else if (!s_csb && !s_web) begin
         @(negedge clk0);
         sram_mem[s_addr] = s_din;
      end
   end

   // Reference model state
   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } flight_t;

   logic [DW-1:0] ref_mem [256];
   flight_t       inflight [$];
   logic [DW-1:0] resp_q [$];
   logic          m_csb;
   logic          m_web;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_din;
   int            edge_no;

   // Observations gathered from the DUT for the hand-written sequences
   logic [DW-1:0] pop_log [$];
   int            pop_cyc [$];
   logic          acc_seen;
   logic          last_ready;
   logic          last_rv;
   logic [DW-1:0] last_rd;
   int            rv_cnt;

   int total;
   int bad;

   // Directed vector table
   typedef struct {
      logic          rst;
      logic          vld;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic          rrdy;
      logic          e_rdy;
      logic          e_csb;
      logic          e_web;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din;
      logic          e_rv;
      logic [DW-1:0] e_rd;
   } vec_t;

   vec_t vecs [9];

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge, then settle briefly.
   task automatic applyStimulus(input logic rst, input logic vld, input logic we,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic rrdy);
      @(negedge clk0);
      rst0      = rst;
      req_valid = vld;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      rsp_ready = rrdy;
      #1;
   endtask

   // A request is accepted whenever outstanding responses plus reads in flight
   // leave room in the response FIFO, and never during reset.
   function automatic logic modelReady(input logic rst);
      return !rst && ((resp_q.size() + inflight.size()) < DEPTH);
   endfunction

   // Compare the DUT outputs with the model's view of this cycle.
   task automatic checkModel(input logic rst);
      checkOutput("req_ready", 32'(req_ready), 32'(modelReady(rst)));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(resp_q.size() != 0));
      if (resp_q.size() != 0) begin
         checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(resp_q[0]));
      end
      checkOutput("csb0", 32'(csb0), 32'(m_csb));
      checkOutput("web0", 32'(web0), 32'(m_web));
      checkOutput("addr0", 32'(addr0), 32'(m_addr));
      checkOutput("din0", 32'(din0), 32'(m_din));
   endtask

   // Advance the model by one rising edge.
   task automatic modelEdge(input logic rst, input logic vld, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic rrdy);
      logic    rdy;
      logic    do_pop;
      flight_t f;
      rdy = modelReady(rst);
      if (rst) begin
         inflight.delete();
         resp_q.delete();
         m_csb  = 1'b1;
         m_web  = 1'b1;
         m_addr = '0;
         m_din  = '0;
      end else begin
         do_pop = (resp_q.size() != 0) && rrdy;
         if (do_pop) begin
            void'(resp_q.pop_front());
         end
         while (inflight.size() != 0 && inflight[0].due == edge_no) begin
            resp_q.push_back(inflight[0].data);
            void'(inflight.pop_front());
         end
         if (vld && rdy) begin
            m_csb  = 1'b0;
            m_web  = !we;
            m_addr = a;
            if (we) begin
               m_din      = wd;
               ref_mem[a] = wd;
            end else begin
               f.data = ref_mem[a];
               f.due  = edge_no + 2;
               inflight.push_back(f);
            end
         end else begin
            m_csb = 1'b1;
            m_web = 1'b1;
         end
      end
      edge_no++;
   endtask

   // One full cycle: drive, check against the model, record observations, clock.
   task automatic runCycle(input logic rst, input logic vld, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic rrdy);
      applyStimulus(rst, vld, we, a, wd, rrdy);
      checkModel(rst);
      last_ready = req_ready;
      last_rv    = rsp_valid;
      last_rd    = rsp_rdata;
      acc_seen   = vld && req_ready && !rst;
      if (rsp_valid) begin
         rv_cnt++;
      end
      if (rsp_valid && rrdy && !rst) begin
         pop_log.push_back(rsp_rdata);
         pop_cyc.push_back(edge_no);
      end
      @(posedge clk0);
      modelEdge(rst, vld, we, a, wd, rrdy);
   endtask

   // Runaway guard
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int acc;
      int wrong;
      int gap;
      int rv_base;

      total   = 0;
      bad     = 0;
      rv_cnt  = 0;
      edge_no = 0;
      dout0   = '0;
      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = 8'(i) ^ 8'h5A;
         ref_mem[i]  = 8'(i) ^ 8'h5A;
      end
      m_csb  = 1'b1;
      m_web  = 1'b1;
      m_addr = '0;
      m_din  = '0;

      rst0      = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 8'h33;
      req_wdata = 8'h77;
      rsp_ready = 1'b1;

      // Reset held with a request offered, then write 0xA5 to 0x10 and read it back
      // on the very next cycle, with one stall cycle on the response.
      vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h33, 8'h77, 1'b1,  1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h33, 8'h77, 1'b1,  1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b1,  1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1,  1'b1, 1'b0, 1'b0, 8'h10, 8'hA5, 1'b0, 8'h00};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1,  1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1,  1'b1, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0,  1'b1, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 8'hA5};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1,  1'b1, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 8'hA5};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1,  1'b1, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00};

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].rrdy);
         checkOutput($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
         checkOutput($sformatf("vec%0d_csb0", i), 32'(csb0), 32'(vecs[i].e_csb));
         checkOutput($sformatf("vec%0d_web0", i), 32'(web0), 32'(vecs[i].e_web));
         checkOutput($sformatf("vec%0d_addr0", i), 32'(addr0), 32'(vecs[i].e_addr));
         checkOutput($sformatf("vec%0d_din0", i), 32'(din0), 32'(vecs[i].e_din));
         checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
         if (vecs[i].e_rv || vecs[i].rst) begin
            checkOutput($sformatf("vec%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rd));
         end
         @(posedge clk0);
         modelEdge(vecs[i].rst, vecs[i].vld, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].rrdy);
      end

      // Fill every address with its own index, then stream 256 reads back to back.
      $display("[TB] fill and streaming read");
      for (int i = 0; i < 256; i++) begin
         runCycle(1'b0, 1'b1, 1'b1, 8'(i), 8'(i), 1'b1);
      end
      pop_log.delete();
      pop_cyc.delete();
      for (int i = 0; i < 256; i++) begin
         runCycle(1'b0, 1'b1, 1'b0, 8'(i), 8'h00, 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         runCycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      end
      checkOutput("fill_rsp_count", 32'(pop_log.size()), 32'd256);
      wrong = 0;
      foreach (pop_log[j]) begin
         if (pop_log[j] !== 8'(j)) wrong++;
      end
      checkOutput("fill_rsp_order_errors", 32'(wrong), 32'd0);
      gap = (pop_cyc.size() == 256) ? (pop_cyc[255] - pop_cyc[0]) : -1;
      checkOutput("fill_rsp_no_gaps", 32'(gap), 32'd255);

      // Back-pressure: six reads offered while the host refuses responses.
      $display("[TB] back-pressure");
      pop_log.delete();
      pop_cyc.delete();
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         runCycle(1'b0, 1'b1, 1'b0, 8'h20 + 8'(acc), 8'h00, 1'b0);
         if (acc_seen) acc++;
      end
      checkOutput("bp_accepted_while_stalled", 32'(acc), 32'd4);
      checkOutput("bp_req_ready_low", 32'(last_ready), 32'd0);
      checkOutput("bp_rsp_valid_high", 32'(last_rv), 32'd1);
      for (int c = 0; c < 12; c++) begin
         runCycle(1'b0, acc < 6, 1'b0, 8'h20 + 8'(acc), 8'h00, 1'b1);
         if (acc_seen) acc++;
      end
      checkOutput("bp_total_accepted", 32'(acc), 32'd6);
      checkOutput("bp_rsp_count", 32'(pop_log.size()), 32'd6);
      wrong = 0;
      foreach (pop_log[j]) begin
         if (pop_log[j] !== 8'h20 + 8'(j)) wrong++;
      end
      checkOutput("bp_rsp_order_errors", 32'(wrong), 32'd0);
      gap = (pop_cyc.size() >= 4) ? (pop_cyc[3] - pop_cyc[0]) : -1;
      checkOutput("bp_four_stored_back_to_back", 32'(gap), 32'd3);

      // Credits exhausted: the last read returns on the same edge the host pops.
      $display("[TB] pop and push on one edge");
      pop_log.delete();
      pop_cyc.delete();
      for (int c = 0; c < 6; c++) begin
         runCycle(1'b0, c < 4, 1'b0, 8'h40 + 8'(c), 8'h00, c == 5);
      end
      runCycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("pp_rsp_valid", 32'(last_rv), 32'd1);
      checkOutput("pp_head_after_pop", 32'(last_rd), 32'h41);
      checkOutput("pp_req_ready_freed", 32'(last_ready), 32'd1);
      for (int c = 0; c < 5; c++) begin
         runCycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      end
      checkOutput("pp_rsp_count", 32'(pop_log.size()), 32'd4);
      wrong = 0;
      foreach (pop_log[j]) begin
         if (pop_log[j] !== 8'h40 + 8'(j)) wrong++;
      end
      checkOutput("pp_rsp_order_errors", 32'(wrong), 32'd0);

      // Reset one cycle after a read is accepted: the read must vanish.
      $display("[TB] reset with read in flight");
      runCycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      pop_log.delete();
      runCycle(1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 1'b1);
      runCycle(1'b1, 1'b1, 1'b0, 8'h66, 8'h00, 1'b1);
      rv_base = rv_cnt;
      for (int c = 0; c < 5; c++) begin
         runCycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      end
      checkOutput("rst_no_rsp_valid_cycles", 32'(rv_cnt - rv_base), 32'd0);
      checkOutput("rst_no_rsp_popped", 32'(pop_log.size()), 32'd0);
      runCycle(1'b0, 1'b1, 1'b0, 8'h42, 8'h00, 1'b1);
      for (int c = 0; c < 3; c++) begin
         runCycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      end
      checkOutput("rst_next_read_count", 32'(pop_log.size()), 32'd1);
      checkOutput("rst_next_read_data", 32'((pop_log.size() != 0) ? pop_log[0] : 8'h00), 32'h42);

      // Random traffic against the reference model, with occasional resets.
      // Addresses are kept in a small range so read-after-write collisions are common.
      $display("[TB] random traffic");
      for (int n = 0; n < 800; n++) begin
         runCycle($urandom_range(0, 99) == 0,
                  ($urandom % 4) != 0,
                  ($urandom % 3) == 0,
                  8'($urandom_range(0, 15)),
                  8'($urandom),
                  ($urandom % 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
